// File: rtl/gol_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : gol_sequencer_if
//  Description : Handshake between the Game-of-Life sequencer and the
//                generation engine.
//                  gen_start : one-cycle pulse, compute one generation
//                  gen_done  : one-cycle pulse, next board is ready
//                  clear     : one-cycle pulse, clear board / abort engine
//                master = sequencer side, slave = engine side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface gol_sequencer_if;
  logic gen_start;
  logic gen_done;
  logic clear;

  modport master (
    output gen_start,
    output clear,
    input  gen_done
  );

  modport slave (
    input  gen_start,
    input  clear,
    output gen_done
  );
endinterface
`default_nettype wire

// File: rtl/gol_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : gol_sequencer
//  Description : Control sequencer for a Game-of-Life engine. Three raw
//                buttons (run/step/clear) are synchronised and debounced
//                into press events that drive a SET/RUN/STOP mode machine.
//                In RUN a prescaler issues generation ticks; each accepted
//                tick or step launches one generation on the engine.
//  Ports       : clk               system clock, rising edge
//                reset             asynchronous reset, active low
//                btn_run_i         raw run/stop button
//                btn_step_i        raw single-step button
//                btn_clear_i       raw clear button
//                speed_i[1:0]      tick period = 2^(TICK_SHIFT + 2*speed_i)
//                eng_if            engine handshake (master side)
//                state_o[2:0]      one-hot mode: 001 SET, 010 RUN, 100 STOP
//                edit_en_o         board editing allowed (mode SET)
//                busy_o            generation outstanding
//                overrun_o         sticky: RUN tick arrived while busy
//                generation_cnt_o  completed generations since clear
//  Revision    : 1.0 - initial release
// ============================================================================
module gol_sequencer #(
  parameter int DEBOUNCE_CYCLES = 65536,
  parameter int TICK_SHIFT      = 22
) (
  input  wire logic        clk,
  input  wire logic        reset,
  input  wire logic        btn_run_i,
  input  wire logic        btn_step_i,
  input  wire logic        btn_clear_i,
  input  wire logic [1:0]  speed_i,
  gol_sequencer_if.master  eng_if,
  output logic [2:0]       state_o,
  output logic             edit_en_o,
  output logic             busy_o,
  output logic             overrun_o,
  output logic [15:0]      generation_cnt_o
);

  localparam logic [2:0] ST_SET  = 3'b001;
  localparam logic [2:0] ST_RUN  = 3'b010;
  localparam logic [2:0] ST_STOP = 3'b100;

  localparam int              DB_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  // Longest period is 2^(TICK_SHIFT+6) (speed 3).
  localparam int              PS_W    = TICK_SHIFT + 6;

  // Button bit order: 0 run, 1 step, 2 clear.
  logic [2:0] btn_raw;
  logic [2:0] btn_meta_q;
  logic [2:0] btn_sync_q;
  logic [2:0] btn_filt;
  logic [2:0] btn_prev_q;
  logic [2:0] press;
  logic       ev_clear;
  logic       ev_run;
  logic       ev_step;

  logic [2:0]      state_q, state_d;
  logic            start_q, start_d;
  logic            clear_q, clear_d;
  logic            busy_q, busy_d;
  logic            overrun_q, overrun_d;
  logic            ovr_set;
  logic            done_acc;
  logic [15:0]     gen_cnt_q, gen_cnt_d;
  logic [PS_W-1:0] presc_q, presc_d;
  logic [PS_W-1:0] tick_mask;
  logic [2:0]      tick_sh;
  logic            tick;

  assign btn_raw = {btn_clear_i, btn_step_i, btn_run_i};

  // --------------------------------------------------------------------------
  // Synchronisers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      btn_meta_q <= '0;
      btn_sync_q <= '0;
      btn_prev_q <= '0;
    end else begin
      btn_meta_q <= btn_raw;
      btn_sync_q <= btn_meta_q;
      btn_prev_q <= btn_filt;
    end
  end

  // --------------------------------------------------------------------------
  // Debouncers: the counter runs only while the synchronised level differs
  // from the filtered one, so any return to the old level restarts the count.
  // --------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_btn
      logic [DB_W-1:0] db_cnt_q;
      logic            filt_q;

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          db_cnt_q <= '0;
          filt_q   <= 1'b0;
        end else if (btn_sync_q[gi] == filt_q) begin
          db_cnt_q <= '0;
        end else if (db_cnt_q == DB_LAST) begin
          db_cnt_q <= '0;
          filt_q   <= btn_sync_q[gi];
        end else begin
          db_cnt_q <= db_cnt_q + DB_W'(1);
        end
      end

      assign btn_filt[gi] = filt_q;
    end
  endgenerate

  // Rising edge of the filtered level; priority clear > run > step.
  assign press    = btn_filt & ~btn_prev_q;
  assign ev_clear = press[2];
  assign ev_run   = press[0] & ~press[2];
  assign ev_step  = press[1] & ~press[2] & ~press[0];

  // --------------------------------------------------------------------------
  // Tick prescaler: a tick fires when the low TICK_SHIFT+2*speed bits are all
  // ones, i.e. exactly one period after the counter was zeroed on RUN entry.
  // --------------------------------------------------------------------------
  always_comb begin
    tick_sh   = 3'd6 - {speed_i, 1'b0};
    tick_mask = {PS_W{1'b1}} >> tick_sh;
    tick      = (state_q == ST_RUN) && ((presc_q & tick_mask) == tick_mask);
    if ((state_d == ST_RUN) && (state_q != ST_RUN)) begin
      presc_d = '0;
    end else begin
      presc_d = presc_q + PS_W'(1);
    end
  end

  // --------------------------------------------------------------------------
  // Mode FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_SET;
    end else begin
      state_q <= state_d;
    end
  end

  // Mode FSM: next state
  always_comb begin
    state_d = state_q;
    if (ev_clear) begin
      state_d = ST_SET;
    end else begin
      case (state_q)
        ST_SET: begin
          if (ev_run) begin
            state_d = ST_RUN;
          end else if (ev_step) begin
            state_d = ST_STOP;
          end
        end
        ST_RUN: begin
          if (ev_run) begin
            state_d = ST_STOP;
          end
        end
        ST_STOP: begin
          if (ev_run) begin
            state_d = ST_RUN;
          end
        end
        default: state_d = ST_SET;
      endcase
    end
  end

  // Mode FSM: outputs. Pulses are decided here and registered below so they
  // appear the cycle after the triggering event.
  always_comb begin
    state_o   = state_q;
    edit_en_o = (state_q == ST_SET);
    start_d   = 1'b0;
    clear_d   = ev_clear;
    ovr_set   = 1'b0;
    if (!ev_clear) begin
      case (state_q)
        ST_SET:  start_d = ev_step & ~busy_q;
        ST_RUN: begin
          // A run press in the same cycle leaves RUN, so the tick is dropped.
          if (!ev_run && tick) begin
            if (busy_q) begin
              ovr_set = 1'b1;
            end else begin
              start_d = 1'b1;
            end
          end
        end
        ST_STOP: start_d = ev_step & ~busy_q;
        default: start_d = 1'b0;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Generation bookkeeping. A done only counts while a generation is
  // outstanding, and is swallowed by a clear in the same cycle. Leaving RUN
  // does not touch busy, so an in-flight generation still completes.
  // --------------------------------------------------------------------------
  always_comb begin
    done_acc  = eng_if.gen_done & busy_q & ~ev_clear;
    busy_d    = busy_q;
    overrun_d = overrun_q | ovr_set;
    gen_cnt_d = gen_cnt_q;
    if (ev_clear) begin
      busy_d    = 1'b0;
      overrun_d = 1'b0;
      gen_cnt_d = '0;
    end else begin
      if (start_d) begin
        busy_d = 1'b1;
      end else if (done_acc) begin
        busy_d = 1'b0;
      end
      if (done_acc) begin
        gen_cnt_d = gen_cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      start_q   <= 1'b0;
      clear_q   <= 1'b0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
      gen_cnt_q <= '0;
      presc_q   <= '0;
    end else begin
      start_q   <= start_d;
      clear_q   <= clear_d;
      busy_q    <= busy_d;
      overrun_q <= overrun_d;
      gen_cnt_q <= gen_cnt_d;
      presc_q   <= presc_d;
    end
  end

  assign eng_if.gen_start = start_q;
  assign eng_if.clear     = clear_q;
  assign busy_o           = busy_q;
  assign overrun_o        = overrun_q;
  assign generation_cnt_o = gen_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_gol_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_gol_sequencer
//  Description : Self-checking bench for gol_sequencer (DEBOUNCE_CYCLES=4,
//                TICK_SHIFT=3). Stimulus pushes expected start/clear pulses
//                into a scoreboard queue; a monitor pops and compares them
//                when the DUT pulses. A small engine model returns done.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_gol_sequencer;

  localparam int         DB   = 4;
  localparam int         TS   = 3;
  localparam logic [2:0] SET  = 3'b001;
  localparam logic [2:0] RUN  = 3'b010;
  localparam logic [2:0] STOP = 3'b100;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        btn_run_i = 1'b0;
  logic        btn_step_i = 1'b0;
  logic        btn_clear_i = 1'b0;
  logic [1:0]  speed_i = 2'd0;
  logic [2:0]  state_o;
  logic        edit_en_o;
  logic        busy_o;
  logic        overrun_o;
  logic [15:0] generation_cnt_o;

  gol_sequencer_if eng_if ();

  gol_sequencer #(
    .DEBOUNCE_CYCLES(DB),
    .TICK_SHIFT     (TS)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .btn_run_i       (btn_run_i),
    .btn_step_i      (btn_step_i),
    .btn_clear_i     (btn_clear_i),
    .speed_i         (speed_i),
    .eng_if          (eng_if),
    .state_o         (state_o),
    .edit_en_o       (edit_en_o),
    .busy_o          (busy_o),
    .overrun_o       (overrun_o),
    .generation_cnt_o(generation_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_clear;
    logic [2:0]  st;
    logic [15:0] cnt;
    int          gap;   // cycles since RUN entry / previous start; 0 = unchecked
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  // Engine model controls
  bit auto_done  = 1'b1;
  int done_delay = 3;
  int done_req   = 0;
  int done_ack   = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic push_start(logic [2:0] st, logic [15:0] cnt, int gap);
    exp_t e;
    e.is_clear = 1'b0;
    e.st       = st;
    e.cnt      = cnt;
    e.gap      = gap;
    sb_q.push_back(e);
  endtask

  task automatic push_clear();
    exp_t e;
    e.is_clear = 1'b1;
    e.st       = SET;
    e.cnt      = 16'h0000;
    e.gap      = 0;
    sb_q.push_back(e);
  endtask

  task automatic set_btn(int idx, logic v);
    case (idx)
      0:       btn_run_i   = v;
      1:       btn_step_i  = v;
      default: btn_clear_i = v;
    endcase
  endtask

  // Hold long enough for sync + debounce, then release and let it settle.
  task automatic press(int idx);
    set_btn(idx, 1'b1);
    repeat (10) @(negedge clk);
    set_btn(idx, 1'b0);
    repeat (8) @(negedge clk);
  endtask

  task automatic wait_cnt(string name, logic [15:0] c, int maxc);
    for (int i = 0; i < maxc && generation_cnt_o !== c; i++) @(negedge clk);
    check(name, generation_cnt_o, c);
  endtask

  // --------------------------------------------------------------------------
  // Engine model: answers each start with a done after done_delay cycles,
  // or on explicit request from the stimulus.
  // --------------------------------------------------------------------------
  initial begin
    int pend;
    pend = 0;
    eng_if.gen_done = 1'b0;
    forever begin
      @(negedge clk);
      eng_if.gen_done = 1'b0;
      if (pend != 0) begin
        pend--;
        if (pend == 0) eng_if.gen_done = 1'b1;
      end else if (done_ack != done_req) begin
        eng_if.gen_done = 1'b1;
        done_ack++;
      end
      if (eng_if.gen_start && auto_done) pend = done_delay;
    end
  end

  // --------------------------------------------------------------------------
  // Monitor: pops the scoreboard on every start/clear pulse.
  // --------------------------------------------------------------------------
  initial begin
    logic [2:0] prev_st;
    int         cyc;
    int         ref_cyc;
    exp_t       e;
    prev_st = SET;
    cyc     = 0;
    ref_cyc = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (reset) begin
        if (state_o == RUN && prev_st != RUN) ref_cyc = cyc;
        if (eng_if.gen_start) begin
          check("start_expected", 32'(sb_q.size() > 0), 32'd1);
          if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check("start_kind", 32'(e.is_clear), 32'd0);
            check("start_state", state_o, e.st);
            check("start_cnt", generation_cnt_o, e.cnt);
            if (e.gap != 0) check("start_gap", cyc - ref_cyc, e.gap);
          end
          ref_cyc = cyc;
        end
        if (eng_if.clear) begin
          check("clear_expected", 32'(sb_q.size() > 0), 32'd1);
          if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check("clear_kind", 32'(e.is_clear), 32'd1);
            check("clear_state", state_o, e.st);
            check("clear_cnt", generation_cnt_o, e.cnt);
            check("clear_busy", busy_o, 1'b0);
          end
        end
      end
      prev_st = state_o;
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  initial begin
    int held;
    repeat (3) @(negedge clk);
    reset = 1'b1;

    // Idle after reset
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      check("idle_outputs",
            {state_o, edit_en_o, eng_if.gen_start, eng_if.clear, busy_o, overrun_o, generation_cnt_o},
            {SET, 1'b1, 4'b0000, 16'h0000});
    end

    // RUN at speed 0: a start every 8 cycles, done 3 cycles after each.
    auto_done  = 1'b1;
    done_delay = 3;
    speed_i    = 2'd0;
    push_start(RUN, 16'd0, 8);
    push_start(RUN, 16'd1, 8);
    push_start(RUN, 16'd2, 8);
    btn_run_i = 1'b1;
    held = 0;
    while (state_o !== RUN && held < 30) begin @(negedge clk); held++; end
    check("run_entry", state_o, RUN);
    while (generation_cnt_o !== 16'd3 && held < 100) begin @(negedge clk); held++; end
    check("run_cnt3", generation_cnt_o, 16'd3);
    speed_i = 2'd3;   // stretch the period so no further tick is due
    while (held < 50) begin @(negedge clk); held++; end
    btn_run_i = 1'b0;
    repeat (10) @(negedge clk);
    check("run_held_single_event", state_o, RUN);
    check("run_no_overrun", overrun_o, 1'b0);
    check("run_not_busy", busy_o, 1'b0);
    press(0);
    check("run_to_stop", state_o, STOP);

    // RUN with done withheld: one start, overrun on the second tick.
    speed_i   = 2'd0;
    auto_done = 1'b0;
    push_start(RUN, 16'd3, 8);
    press(0);
    for (int i = 0; i < 20 && overrun_o !== 1'b1; i++) @(negedge clk);
    speed_i = 2'd3;
    check("ovr_set", overrun_o, 1'b1);
    check("ovr_cnt_held", generation_cnt_o, 16'd3);
    check("ovr_busy", busy_o, 1'b1);
    check("ovr_state", state_o, RUN);
    done_req++;
    wait_cnt("ovr_done_cnt", 16'd4, 10);
    check("ovr_busy_clr", busy_o, 1'b0);
    press(0);
    check("ovr_to_stop", state_o, STOP);
    check("ovr_sticky", overrun_o, 1'b1);

    // STOP: two single steps, then a short glitch.
    auto_done = 1'b1;
    push_start(STOP, 16'd4, 0);
    press(1);
    wait_cnt("step1_cnt", 16'd5, 20);
    push_start(STOP, 16'd5, 0);
    press(1);
    wait_cnt("step2_cnt", 16'd6, 20);
    check("step_state", state_o, STOP);
    btn_step_i = 1'b1;
    repeat (2) @(negedge clk);
    btn_step_i = 1'b0;
    repeat (20) @(negedge clk);
    check("glitch_state", state_o, STOP);
    check("glitch_cnt", generation_cnt_o, 16'd6);

    // Clear and run together while busy; a later done is ignored.
    auto_done = 1'b0;
    push_start(STOP, 16'd6, 0);
    press(1);
    check("pre_clear_busy", busy_o, 1'b1);
    push_clear();
    btn_clear_i = 1'b1;
    btn_run_i   = 1'b1;
    for (int i = 0; i < 20 && eng_if.clear !== 1'b1; i++) @(negedge clk);
    check("clear_seen", eng_if.clear, 1'b1);
    repeat (2) @(negedge clk);
    done_req++;
    repeat (8) @(negedge clk);
    btn_clear_i = 1'b0;
    btn_run_i   = 1'b0;
    repeat (10) @(negedge clk);
    check("clr_state", {state_o, edit_en_o}, {SET, 1'b1});
    check("clr_cnt", generation_cnt_o, 16'd0);
    check("clr_busy", busy_o, 1'b0);
    check("clr_overrun", overrun_o, 1'b0);

    // Counter wrap: preload near the top instead of 65534 generations.
    auto_done = 1'b1;
    @(negedge clk);
    force dut.gen_cnt_q = 16'hFFFE;
    @(negedge clk);
    release dut.gen_cnt_q;
    check("preload", generation_cnt_o, 16'hFFFE);
    push_start(STOP, 16'hFFFE, 0);
    press(1);
    wait_cnt("wrap_ffff", 16'hFFFF, 20);
    push_start(STOP, 16'hFFFF, 0);
    press(1);
    wait_cnt("wrap_zero", 16'h0000, 20);
    check("wrap_busy", busy_o, 1'b0);
    check("wrap_state", state_o, STOP);

    // Asynchronous reset between clock edges.
    push_start(STOP, 16'd0, 0);
    press(1);
    wait_cnt("pre_rst_cnt", 16'd1, 20);
    @(negedge clk);
    #2 reset = 1'b0;
    #1 check("async_reset",
             {state_o, eng_if.gen_start, eng_if.clear, busy_o, overrun_o, generation_cnt_o},
             {SET, 4'b0000, 16'h0000});
    @(negedge clk);
    reset = 1'b1;
    repeat (5) @(negedge clk);
    check("sb_empty", sb_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/gol_sequencer.md
GOL_SEQUENCER -- requirements
Module: gol_sequencer

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 65536: consecutive stable cycles required to accept a button level change.
REQ-002 Parameter TICK_SHIFT, default 22: base log2 of the generation tick period in clk cycles.
REQ-003 clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset; asserted when 0.
REQ-005 btn_run_i  input  1  raw run/stop button, asynchronous to clk.
REQ-006 btn_step_i  input  1  raw single-step button, asynchronous to clk.
REQ-007 btn_clear_i  input  1  raw clear button, asynchronous to clk.
REQ-008 speed_i  input  2  run speed select; tick period = 2^(TICK_SHIFT + 2*speed_i) cycles.
REQ-009 gen_done_i  input  1  one-cycle pulse from the generation engine: next board computed.
REQ-010 state_o  output  3  one-hot mode: 3'b001 SET, 3'b010 RUN, 3'b100 STOP.
REQ-011 gen_start_o  output  1  one-cycle pulse: engine computes one generation.
REQ-012 clear_o  output  1  one-cycle pulse: clear board and abort engine.
REQ-013 edit_en_o  output  1  board editing allowed; equals state_o == SET.
REQ-014 busy_o  output  1  generation outstanding (gen_start_o issued, gen_done_i not yet seen).
REQ-015 overrun_o  output  1  sticky: a RUN tick arrived while busy_o was high.
REQ-016 generation_cnt_o  output  16  completed generations since last clear.

Function
REQ-017 Each button SHALL pass through a 2-flop synchronizer, then a debouncer that updates its filtered level only after DEBOUNCE_CYCLES consecutive cycles of a constant synchronized value.
REQ-018 A press event SHALL be a one-cycle pulse on the filtered level's 0->1 transition; holding a button SHALL yield exactly one event.
REQ-019 Event priority in one cycle: clear > run > step; lower-priority events in that cycle SHALL be discarded.
REQ-020 Clear event, any state: next state SET, clear_o pulses the following cycle, generation_cnt_o <= 0, busy_o <= 0, overrun_o <= 0; a gen_done_i in the same cycle SHALL be ignored.
REQ-021 SET: run -> RUN; step -> STOP with one gen_start_o if busy_o is low.
REQ-022 RUN: run -> STOP; step ignored; on tick with busy_o low, gen_start_o pulses the next cycle and busy_o sets; on tick with busy_o high, no start, overrun_o sets.
REQ-023 STOP: run -> RUN; step with busy_o low -> one gen_start_o, state remains STOP; step with busy_o high is discarded.
REQ-024 Tick prescaler: free-running counter, cleared on every entry to RUN; first tick exactly 2^(TICK_SHIFT+2*speed_i) cycles after entry; speed_i sampled continuously.
REQ-025 gen_done_i with busy_o high: busy_o clears and generation_cnt_o increments the same edge; gen_done_i with busy_o low SHALL be ignored.
REQ-026 Leaving RUN with busy_o high SHALL NOT abort the generation; its completion still counts.
REQ-027 generation_cnt_o SHALL wrap 16'hFFFF -> 16'h0000 without side effects.
REQ-028 gen_start_o and gen_done_i in the same cycle cannot both be accepted: start requires busy_o low, done requires busy_o high.

Reset
REQ-029 While reset = 0: state_o = 3'b001, gen_start_o = 0, clear_o = 0, busy_o = 0, overrun_o = 0, generation_cnt_o = 0, and the prescaler, synchronizers and debouncers hold 0.
REQ-030 Reset assertion SHALL take effect immediately without clk; deassertion is synchronized by the system; first state change allowed on the first clk edge after release.

Verification (DEBOUNCE_CYCLES=4, TICK_SHIFT=3)
REQ-031 Reset release, no input -> state_o=001, edit_en_o=1, all other outputs 0 for 100 cycles.
REQ-032 Run press held 50 cycles, speed_i=0, gen_done_i returned 3 cycles after each start -> state_o=010, gen_start_o every 8 cycles, generation_cnt_o=3 after the third done.
REQ-033 RUN with gen_done_i withheld 20 cycles -> one gen_start_o only, overrun_o=1 after the second tick, count unchanged until done.
REQ-034 STOP, step pressed twice with done between -> two gen_start_o pulses, count +2, state_o stays 100; 2-cycle glitch on btn_step_i -> no event.
REQ-035 Clear and run released the same cycle while busy -> state_o=001, clear_o one pulse, count=0, busy_o=0; a done 2 cycles later is ignored.
REQ-036 Count preloaded to 16'hFFFF via 65535 steps, one more done -> generation_cnt_o=16'h0000.
